sync_fifo_wr_arb: RTL and testbench
===================================

# sync_fifo_wr_arb

Round-robin write arbiter that shares the single write port of one `sync_fifo` instance between `NUM_REQ` producers. Each producer has a valid/ready handshake. The arbiter multiplexes the winning producer's data onto the FIFO `wr_en`/`din` pair and honours the FIFO `full` flag as backpressure. A granted producer may hold the port for up to `MAX_BURST` consecutive beats before rotation, so bursts stay contiguous in the FIFO.

## Interface
Parameters:
- `DATA_WIDTH`, 8: width of each producer word and of the FIFO `din`.
- `NUM_REQ`, 4: number of producers, ≥ 2.
- `MAX_BURST`, 4: maximum beats per grant, ≥ 1; 1 gives pure per-beat round-robin.
- Derived: `ID_W` = max(1, $clog2(NUM_REQ)); `CNT_W` = max(1, $clog2(MAX_BURST+1)).

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  bit i: producer i presents a word.
- `req_data`  in  `NUM_REQ*DATA_WIDTH`  producer i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  `NUM_REQ`  bit i: producer i word accepted this cycle; one-hot or zero.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_wr_en`  out  1  write strobe to FIFO.
- `fifo_din`  out  `DATA_WIDTH`  write data to FIFO.
- `grant_id`  out  `ID_W`  registered index of the current or most recent owner.
- `busy`  out  1  high while in BURST state.

## Operation
- Transfer for producer i occurs in any cycle where `req_valid[i] && req_ready[i]`.
- `fifo_wr_en` = |`req_ready`. `fifo_din` = `req_data` slice of the ready producer, or 0 when there is no transfer.
- `req_ready` is never asserted while `fifo_full` = 1. Nothing is written into a full FIFO.
- State `rr_ptr` (`ID_W`): highest-priority index, reset 0.
- State `owner` (`ID_W`), `beat_cnt` (`CNT_W`).
- FSM states: IDLE, BURST.
- IDLE:
  - Winner = first i with `req_valid[i]`, scanning `rr_ptr`, `rr_ptr+1`, … modulo `NUM_REQ`.
  - If a winner exists and `fifo_full` = 0: transfer winner, `owner` ← winner, `grant_id` ← winner.
  - If `MAX_BURST` = 1: `rr_ptr` ← winner+1 (mod `NUM_REQ`), stay IDLE.
  - Otherwise: `beat_cnt` ← 1, go BURST.
  - If a winner exists but `fifo_full` = 1: no transfer, no state change. Priority is re-evaluated next cycle.
- BURST (only `owner` eligible):
  - `req_valid[owner]` && !`fifo_full`: transfer, `beat_cnt`++.
    - If the new count = `MAX_BURST`: `rr_ptr` ← owner+1, go IDLE.
  - `req_valid[owner]` && `fifo_full`: hold. No transfer, count unchanged.
  - !`req_valid[owner]`: release. No transfer this cycle, `rr_ptr` ← owner+1, go IDLE. Other producers wait one cycle.
- Wrap-around: `rr_ptr` and owner+1 wrap from `NUM_REQ-1` to 0. Non-power-of-two `NUM_REQ` must wrap explicitly, never via bit overflow.
- Producer contract: `req_data[i]` must be stable while `req_valid[i]` = 1 and not accepted. The arbiter does not check this.

## Timing
- Accept path is combinational from `req_valid`, `fifo_full` and registered state to `req_ready`/`fifo_wr_en`/`fifo_din`. Latency is zero cycles.
- A word is in FIFO storage after the same rising edge that accepts it.
- Throughput: one word per cycle while the FIFO is not full. A release-by-drop costs one idle cycle.
- Reset values:
  - State: `rr_ptr` = 0, `owner` = 0, `beat_cnt` = 0, state IDLE.
  - Outputs: `grant_id` = 0, `busy` = 0.
  - While `rst_n` = 0, `req_ready` = 0, `fifo_wr_en` = 0 and `fifo_din` = 0 regardless of inputs.
- Reset mid-burst: aborts immediately. After release, arbitration restarts from producer 0. Words already written stay in the FIFO; the FIFO's own reset governs them.
- `fifo_full` deasserting: acceptance resumes in the same cycle.

## Test plan
- **Reset.** Assert `rst_n` = 0 with all `req_valid` = 1 → `req_ready` = 0, `fifo_wr_en` = 0, `grant_id` = 0, `busy` = 0. After release with only producer 2 valid → producer 2 is accepted in the first cycle.
- **Round-robin, `MAX_BURST` = 1.** All 4 valid continuously; producer i data = 0x10+i → FIFO receives 0x10, 0x11, 0x12, 0x13, 0x10 … one per cycle with no gaps.
- **Burst, `MAX_BURST` = 4.** Producers 0 and 1 continuously valid with distinct counters → 4 beats from 0, then 4 from 1, then 0 again. `busy` is high after the first beat of each burst.
- **Early release.** Producer 3 drops valid after 2 beats while producer 1 is valid → one idle cycle, then producer 1 (scan starts at 0, wraps). `grant_id` goes 3 → 1.
- **Backpressure.** Against a `sync_fifo` with `FIFO_DEPTH` = 10, all producers valid → exactly 10 writes, then `fifo_wr_en` = 0 while full. After 3 FIFO reads, 3 more writes land, continuing the interrupted owner's burst. No word is lost or duplicated per scoreboard.
- **Reset mid-burst.** Producer 1 is owner with `beat_cnt` = 2; pulse `rst_n` → `busy` = 0 and `rr_ptr` = 0. With producers 0 and 1 valid, the next grant goes to producer 0.

Source files
------------

// File: rtl/sync_fifo_wr_arb.sv
// Round-robin write arbiter: NUM_REQ valid/ready producers share one sync_fifo write port,
// with up to MAX_BURST contiguous beats per grant and fifo_full as backpressure.
module sync_fifo_wr_arb #(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_REQ    = 4,
  parameter  int MAX_BURST  = 4,
  localparam int ID_W       = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W      = ($clog2(MAX_BURST + 1) > 1) ? $clog2(MAX_BURST + 1) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_din,
  output logic [ID_W-1:0]               o_grant_id,
  output logic                          o_busy
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t               r_state, w_state_nxt;
  logic [ID_W-1:0]      r_rr_ptr, r_owner, w_rr_nxt, w_owner_nxt, w_win, w_cand;
  logic [CNT_W-1:0]     r_beat_cnt, w_cnt_nxt;
  logic                 w_win_vld;
  logic [NUM_REQ-1:0]   w_ready;
  logic [DATA_WIDTH-1:0] w_din;

  // Explicit wrap so non-power-of-two NUM_REQ never overflows into an invalid index.
  function automatic logic [ID_W-1:0] f_inc(input logic [ID_W-1:0] x);
    return (x == ID_W'(NUM_REQ - 1)) ? '0 : x + ID_W'(1);
  endfunction

  always_comb begin
    int idx;
    w_win_vld = 1'b0;
    w_win     = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      w_cand = ID_W'(idx);
      if (!w_win_vld && i_req_valid[w_cand]) begin
        w_win_vld = 1'b1;
        w_win     = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_beat_cnt;
    w_ready     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld && !i_fifo_full) begin
          w_ready[w_win] = 1'b1;
          w_owner_nxt    = w_win;
          if (MAX_BURST == 1) begin
            w_rr_nxt = f_inc(w_win);
          end else begin
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = S_BURST;
          end
        end
      end
      S_BURST: begin
        // Owner dropping valid releases the port; others see it next cycle.
        if (!i_req_valid[r_owner]) begin
          w_rr_nxt    = f_inc(r_owner);
          w_state_nxt = S_IDLE;
        end else if (!i_fifo_full) begin
          w_ready[r_owner] = 1'b1;
          w_cnt_nxt        = r_beat_cnt + CNT_W'(1);
          if (w_cnt_nxt == CNT_W'(MAX_BURST)) begin
            w_rr_nxt    = f_inc(r_owner);
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_cnt_nxt;
    end
  end

  // Reset gates the combinational accept path so nothing leaks out while held.
  assign o_req_ready  = rst_n ? w_ready : '0;
  assign o_fifo_wr_en = |o_req_ready;

  always_comb begin
    w_din = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (o_req_ready[i]) w_din = w_din | i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign o_fifo_din = w_din;
  assign o_grant_id = r_owner;
  assign o_busy     = (r_state == S_BURST);

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Bench for sync_fifo_wr_arb: directed vector table, corner sequences and random traffic
// checked against a queue-based FIFO and a behavioural arbitration model.
module tb_sync_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic        fifo_full = 1'b0;

  logic [3:0]  rdy4, rdy1;
  logic        wen4, wen1, busy4, busy1;
  logic [7:0]  din4, din1;
  logic [1:0]  gid4, gid1;

  int total = 0;
  int bad = 0;
  int nwr = 0;

  always #5 clk = ~clk;

  sync_fifo_wr_arb #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(rdy4), .i_fifo_full(fifo_full), .o_fifo_wr_en(wen4),
    .o_fifo_din(din4), .o_grant_id(gid4), .o_busy(busy4));

  sync_fifo_wr_arb #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(rdy1), .i_fifo_full(fifo_full), .o_fifo_wr_en(wen1),
    .o_fifo_din(din1), .o_grant_id(gid1), .o_busy(busy1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: holder = producer owning a burst (-1 when none).
  int mrr[2], mhold[2], mbeats[2], mlast[2];
  logic [5:0] seq[4], rdseq[4];
  logic [7:0] q[$];

  function automatic int mb(input int m);
    return (m == 0) ? 4 : 1;
  endfunction

  function automatic int scan(input int m, input logic [3:0] v);
    for (int k = 0; k < 4; k++)
      if (v[(mrr[m] + k) % 4]) return (mrr[m] + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] mexp(input int m, input logic [3:0] v, input logic full);
    logic [3:0] r;
    int w;
    r = '0;
    if (!full) begin
      if (mhold[m] >= 0) begin
        if (v[mhold[m]]) r[mhold[m]] = 1'b1;
      end else begin
        w = scan(m, v);
        if (w >= 0) r[w] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic mupdate(input int m, input logic [3:0] v, input logic full);
    int w;
    if (mhold[m] >= 0) begin
      if (!v[mhold[m]]) begin
        mrr[m] = (mhold[m] + 1) % 4; mhold[m] = -1;
      end else if (!full) begin
        mbeats[m]++;
        if (mbeats[m] == mb(m)) begin mrr[m] = (mhold[m] + 1) % 4; mhold[m] = -1; end
      end
    end else if (!full) begin
      w = scan(m, v);
      if (w >= 0) begin
        mlast[m] = w;
        if (mb(m) == 1) mrr[m] = (w + 1) % 4;
        else begin mhold[m] = w; mbeats[m] = 1; end
      end
    end
  endtask

  function automatic logic [7:0] expdin(input logic [3:0] e);
    for (int i = 0; i < 4; i++)
      if (e[i]) return {2'(i), seq[i]};
    return 8'h00;
  endfunction

  // One cycle, entered and left 1 time unit after a rising edge.
  task automatic mcycle(input logic [3:0] v, input bit rd);
    logic [3:0] e0, e1;
    logic [7:0] x;
    logic       full;
    req_valid = v;
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = {2'(i), seq[i]};
    fifo_full = (q.size() >= 10);
    full = fifo_full;
    #4;
    e0 = mexp(0, v, full);
    e1 = mexp(1, v, full);
    chk("rdy4", rdy4, e0);  chk("wen4", wen4, |e0);  chk("din4", din4, expdin(e0));
    chk("gid4", gid4, mlast[0]);  chk("busy4", busy4, mhold[0] >= 0);
    chk("rdy1", rdy1, e1);  chk("wen1", wen1, |e1);  chk("din1", din1, expdin(e1));
    chk("gid1", gid1, mlast[1]);  chk("busy1", busy1, 0);
    @(posedge clk);
    if (rd && q.size() > 0) begin
      x = q.pop_front();
      chk("fifo_order", x, {x[7:6], rdseq[x[7:6]]});
      rdseq[x[7:6]] = rdseq[x[7:6]] + 6'd1;
    end
    if (wen4) begin q.push_back(din4); nwr++; end
    for (int i = 0; i < 4; i++) if (e0[i]) seq[i] = seq[i] + 6'd1;
    mupdate(0, v, full);
    mupdate(1, v, full);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 4'hF;
    fifo_full = 1'b0;
    #3;
    chk("rst_rdy4", rdy4, 0);  chk("rst_wen4", wen4, 0);  chk("rst_din4", din4, 0);
    chk("rst_busy4", busy4, 0);  chk("rst_gid4", gid4, 0);  chk("rst_rdy1", rdy1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int m = 0; m < 2; m++) begin mrr[m] = 0; mhold[m] = -1; mbeats[m] = 0; mlast[m] = 0; end
    q.delete();
    for (int i = 0; i < 4; i++) rdseq[i] = seq[i];
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic       full;
    logic [3:0] r4;
    logic       b4;
    logic [1:0] g4;
    logic [3:0] r1;
    logic [1:0] g1;
  } vec_t;

  function automatic logic [7:0] tdin(input logic [3:0] r);
    for (int i = 0; i < 4; i++)
      if (r[i]) return 8'h10 + 8'(i);
    return 8'h00;
  endfunction

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 2'd0};
    tbl[1]  = '{1'b1, 4'h4, 1'b0, 4'h4, 1'b0, 2'd0, 4'h4, 2'd0};
    tbl[2]  = '{1'b1, 4'h4, 1'b1, 4'h0, 1'b1, 2'd2, 4'h0, 2'd2};
    tbl[3]  = '{1'b1, 4'hF, 1'b0, 4'h4, 1'b1, 2'd2, 4'h8, 2'd2};
    tbl[4]  = '{1'b1, 4'hB, 1'b0, 4'h0, 1'b1, 2'd2, 4'h1, 2'd3};
    tbl[5]  = '{1'b1, 4'hB, 1'b0, 4'h8, 1'b0, 2'd2, 4'h2, 2'd0};
    tbl[6]  = '{1'b1, 4'hB, 1'b0, 4'h8, 1'b1, 2'd3, 4'h8, 2'd1};
    tbl[7]  = '{1'b1, 4'hB, 1'b0, 4'h8, 1'b1, 2'd3, 4'h1, 2'd3};
    tbl[8]  = '{1'b1, 4'hB, 1'b0, 4'h8, 1'b1, 2'd3, 4'h2, 2'd0};
    tbl[9]  = '{1'b1, 4'hB, 1'b1, 4'h0, 1'b0, 2'd3, 4'h0, 2'd1};
    tbl[10] = '{1'b1, 4'hB, 1'b0, 4'h1, 1'b0, 2'd3, 4'h8, 2'd1};
    for (int i = 0; i < 4; i++) begin seq[i] = 6'(i * 7); rdseq[i] = seq[i]; end

    req_data = 32'h13121110;
    @(posedge clk);
    #1;
    for (int r = 0; r < 11; r++) begin
      rst_n = tbl[r].rst;  req_valid = tbl[r].v;  fifo_full = tbl[r].full;
      #4;
      chk($sformatf("tbl%0d_rdy4", r), rdy4, tbl[r].r4);
      chk($sformatf("tbl%0d_din4", r), din4, tdin(tbl[r].r4));
      chk($sformatf("tbl%0d_busy4", r), busy4, tbl[r].b4);
      chk($sformatf("tbl%0d_gid4", r), gid4, tbl[r].g4);
      chk($sformatf("tbl%0d_rdy1", r), rdy1, tbl[r].r1);
      chk($sformatf("tbl%0d_gid1", r), gid1, tbl[r].g1);
      @(posedge clk);
      #1;
    end

    // Reset mid-burst: producer 1 owns with two beats, then reset restarts from 0.
    do_reset();
    mcycle(4'b0010, 0);
    mcycle(4'b0010, 0);
    chk("mid_busy", busy4, 1);
    do_reset();
    mcycle(4'b0011, 0);
    chk("mid_regrant", gid4, 0);

    // Early release: owner 3 drops after 2 beats, one idle cycle, then producer 1.
    do_reset();
    mcycle(4'b1000, 0);
    mcycle(4'b1000, 0);
    mcycle(4'b0010, 0);
    chk("rel_gid3", gid4, 3);
    mcycle(4'b0010, 0);
    chk("rel_gid1", gid4, 1);

    // Backpressure against a depth-10 FIFO.
    do_reset();
    nwr = 0;
    for (int c = 0; c < 14; c++) mcycle(4'hF, 0);
    chk("bp_writes", nwr, 10);
    for (int c = 0; c < 3; c++) mcycle(4'hF, 1);
    for (int c = 0; c < 6; c++) mcycle(4'hF, 0);
    chk("bp_resume", nwr, 13);

    // Random traffic with random FIFO drain.
    for (int c = 0; c < 800; c++)
      mcycle(4'($urandom_range(0, 15)), $urandom_range(0, 99) < 55);
    for (int c = 0; c < 12; c++) mcycle(4'h0, 1);
    chk("drain_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
